// File: rtl/sigdelay_pkg.sv
// -----------------------------------------------------------------------------
// sigdelay_pkg
// Shared type definitions for the sigdelay audio delay line.
//   state_t : history-tracking state of the delay line
//             IDLE - out of reset, no sample accepted yet
//             FILL - samples accepted, but not enough history for `offset`
//             RUN  - enough history exists, delayed samples are valid
// Widths stay as module parameters; only the enum is shared.
// -----------------------------------------------------------------------------
package sigdelay_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

endpackage : sigdelay_pkg

// File: rtl/ram2port.sv
// -----------------------------------------------------------------------------
// ram2port
// Simple dual-port RAM: one synchronous write port, one synchronous read port
// with a registered output. Maps onto a block RAM.
//
// Ports:
//   clk      in  1        clock
//   wr_en    in  1        write strobe
//   wr_addr  in  A_WIDTH  write address
//   din      in  D_WIDTH  write data
//   rd_addr  in  A_WIDTH  read address (sampled every cycle)
//   dout     out D_WIDTH  registered read data
//
// On a same-address collision the read returns the data stored before the
// write (read-old-data). The contents have no reset.
// -----------------------------------------------------------------------------
module ram2port #(
  parameter int A_WIDTH = 9,
  parameter int D_WIDTH = 8
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [A_WIDTH-1:0] wr_addr,
  input  logic [D_WIDTH-1:0] din,
  input  logic [A_WIDTH-1:0] rd_addr,
  output logic [D_WIDTH-1:0] dout
);

  localparam int DEPTH = 1 << A_WIDTH;

  logic [D_WIDTH-1:0] r_mem [0:DEPTH-1];
  logic [D_WIDTH-1:0] r_dout;

  // The read samples r_mem before the non-blocking write lands, which gives
  // read-old-data behaviour on a collision.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= din;
    end
    r_dout <= r_mem[rd_addr];
  end

  assign dout = r_dout;

endmodule : ram2port

// File: rtl/sigdelay.sv
// -----------------------------------------------------------------------------
// sigdelay
// Audio delay line. Every accepted sample is written into a circular buffer of
// N = 2^A_WIDTH entries; the sample written `offset` samples earlier is read
// back on the same edge and presented one cycle later. Output is suppressed
// (out_valid low, delayed_signal held) until `offset` samples of history exist.
//
// Ports:
//   clk             in  1        clock
//   rst             in  1        synchronous active-high reset
//   en              in  1        sample strobe
//   mic_signal      in  D_WIDTH  input sample
//   offset          in  A_WIDTH  delay in samples (0..N-1), used per sample
//   delayed_signal  out D_WIDTH  delayed sample
//   out_valid       out 1        one-cycle strobe: delayed_signal just updated
// -----------------------------------------------------------------------------
module sigdelay
  import sigdelay_pkg::*;
#(
  parameter int A_WIDTH = 9,
  parameter int D_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [D_WIDTH-1:0] mic_signal,
  input  logic [A_WIDTH-1:0] offset,
  output logic [D_WIDTH-1:0] delayed_signal,
  output logic               out_valid
);

  localparam logic [A_WIDTH-1:0] ADDR_ONE = A_WIDTH'(1);
  localparam logic [A_WIDTH-1:0] FILL_MAX = '1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t             r_state;
  logic [A_WIDTH-1:0] r_wr_addr;
  logic [A_WIDTH-1:0] r_fill;       // accepted samples, saturating at N-1
  logic               r_out_valid;
  logic               r_bypass;     // last accepted sample used offset = 0
  logic [D_WIDTH-1:0] r_byp_data;   // that sample, for the bypass path
  logic [D_WIDTH-1:0] r_held;       // value shown while out_valid is low

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic               w_wr_en;
  logic [A_WIDTH-1:0] w_rd_addr;
  logic [D_WIDTH-1:0] w_ram_dout;
  logic               w_offset_zero;
  logic               w_hist_ok;
  state_t             w_state_next;
  logic [D_WIDTH-1:0] w_delayed;

  // Reset wins over the sample strobe, so no write happens in a reset cycle.
  assign w_wr_en       = en & ~rst;
  // Natural A_WIDTH-bit wrap implements (k - offset) mod N.
  assign w_rd_addr     = r_wr_addr - offset;
  assign w_offset_zero = (offset == '0);
  // r_fill equals the index k of the incoming sample until it saturates; once
  // saturated at N-1 it is still >= every legal offset.
  assign w_hist_ok     = (r_fill >= offset);

  // Next state for the incoming sample, using its own offset and the
  // pre-increment fill count.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    w_state_next = w_offset_zero ? RUN : FILL;
      FILL:    if (w_hist_ok)  w_state_next = RUN;
      RUN:     if (!w_hist_ok) w_state_next = FILL;
      default: w_state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sample buffer
  // ---------------------------------------------------------------------------
  ram2port #(
    .A_WIDTH (A_WIDTH),
    .D_WIDTH (D_WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (w_wr_en),
    .wr_addr (r_wr_addr),
    .din     (mic_signal),
    .rd_addr (w_rd_addr),
    .dout    (w_ram_dout)
  );

  // ---------------------------------------------------------------------------
  // Control FSM, counters and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_wr_addr   <= '0;
      r_fill      <= '0;
      r_out_valid <= 1'b0;
      r_bypass    <= 1'b0;
      r_byp_data  <= '0;
      r_held      <= '0;
    end else begin
      // Remember whatever is on the output so it can be held afterwards.
      r_held      <= w_delayed;
      r_out_valid <= 1'b0;
      if (en) begin
        r_wr_addr <= r_wr_addr + ADDR_ONE;
        if (r_fill != FILL_MAX) begin
          r_fill <= r_fill + ADDR_ONE;
        end
        r_state     <= w_state_next;
        // The transition sample into RUN is itself valid.
        r_out_valid <= (w_state_next == RUN);
        // At offset 0 the RAM read collides with the write and returns the
        // old contents, so the fresh sample is forwarded instead.
        r_bypass    <= w_offset_zero;
        r_byp_data  <= mic_signal;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output selection
  // ---------------------------------------------------------------------------
  // Every source here is a register (RAM output register, bypass register,
  // hold register), so the output changes only at clock edges. The RAM output
  // register re-reads every cycle, hence the hold register for idle cycles.
  always_comb begin
    w_delayed = r_held;
    if (r_out_valid) begin
      w_delayed = r_bypass ? r_byp_data : w_ram_dout;
    end
  end

  assign delayed_signal = w_delayed;
  assign out_valid      = r_out_valid;

endmodule : sigdelay

// File: tb/tb_sigdelay.sv
// -----------------------------------------------------------------------------
// tb_sigdelay
// Scoreboard bench for sigdelay. The stimulus process drives one cycle at a
// time and pushes the expected output (valid, data, state) for the following
// edge; a monitor process pops and compares on the falling edge.
// Input is always a ramp s_k = k mod 256, so the expected delayed value is
// (k - offset) mod 256 once k >= offset.
// -----------------------------------------------------------------------------
module tb_sigdelay;
  import sigdelay_pkg::*;

  localparam int A_W = 9;
  localparam int D_W = 8;

  logic           clk;
  logic           rst;
  logic           en;
  logic [D_W-1:0] mic_signal;
  logic [A_W-1:0] offset;
  logic [D_W-1:0] delayed_signal;
  logic           out_valid;

  sigdelay #(.A_WIDTH(A_W), .D_WIDTH(D_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .mic_signal     (mic_signal),
    .offset         (offset),
    .delayed_signal (delayed_signal),
    .out_valid      (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int             due;
    logic           v;
    logic [D_W-1:0] d;
    state_t         st;
    string          tag;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  // Bench-side reference state
  int             k        = 0;
  logic [D_W-1:0] exp_hold = '0;
  state_t         m_state  = IDLE;
  string          tname    = "init";

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due == cyc) begin
      exp_t e;
      e = sb.pop_front();
      $display("txn cyc=%0d %s: valid=%0b data=%0d state=%0d (exp %0b/%0d/%0d)",
               cyc, e.tag, out_valid, delayed_signal, int'(dut.r_state),
               e.v, e.d, int'(e.st));
      checks++;
      if (out_valid !== e.v) begin
        errors++;
        $display("FAIL %s out_valid cyc=%0d: got %0b expected %0b", e.tag, cyc, out_valid, e.v);
      end
      checks++;
      if (delayed_signal !== e.d) begin
        errors++;
        $display("FAIL %s delayed_signal cyc=%0d: got %0d expected %0d", e.tag, cyc, delayed_signal, e.d);
      end
      checks++;
      if (dut.r_state !== e.st) begin
        errors++;
        $display("FAIL %s state cyc=%0d: got %0d expected %0d", e.tag, cyc, int'(dut.r_state), int'(e.st));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus: one call = one clock cycle
  // ---------------------------------------------------------------------------
  task automatic step(input logic r, input logic e, input int off);
    exp_t x;
    logic ok;
    @(negedge clk);
    rst        = r;
    en         = e;
    offset     = A_W'(off);
    mic_signal = D_W'(k);
    x.due = cyc + 1;
    x.tag = tname;
    if (r) begin
      k        = 0;
      exp_hold = '0;
      m_state  = IDLE;
      x.v      = 1'b0;
    end else if (e) begin
      ok = (k >= off);
      if (ok) exp_hold = D_W'(k - off);
      m_state = ok ? RUN : FILL;
      x.v     = ok;
      k++;
    end else begin
      x.v = 1'b0;
    end
    x.d  = exp_hold;
    x.st = m_state;
    sb.push_back(x);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 5);
  endtask

  task automatic ramp(input int n, input int off);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, off);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mic_signal = '0; offset = '0;

    tname = "reset";
    do_reset(2);
    step(1'b0, 1'b0, 0);          // idle cycle: outputs stay at reset values

    tname = "off64";
    ramp(150, 64);

    tname = "off0";
    do_reset(1);
    ramp(40, 0);

    tname = "off511";
    do_reset(1);
    ramp(1000, 511);

    tname = "en_toggle";
    do_reset(1);
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b1, 8);
      step(1'b0, 1'b0, 8);
    end

    tname = "off_raise";
    do_reset(1);
    ramp(50, 16);
    ramp(80, 100);
    tname = "off_lower";
    ramp(10, 20);

    tname = "mid_reset";
    do_reset(1);
    ramp(300, 64);
    do_reset(1);                  // en held high during reset
    tname = "post_reset";
    ramp(100, 64);

    step(1'b0, 1'b0, 64);
    step(1'b0, 1'b0, 64);

    // Let the monitor drain, bounded
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_sigdelay
